// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
//
// One shared seconds countdown timer, time-multiplexed between three
// requesters (0 = anti-theft FSM, 1 = fuel-pump lockout, 2 = siren cadence).
// A requester holds its req bit high for as long as it wants the timer. The
// winner's countdown length is captured only at the grant edge. When the
// countdown runs out, the owner receives a one-cycle expired pulse. If the
// owner drops req before then, the countdown aborts and no pulse is issued.
//
// Build option:
//   TIMER_SCHED_RR_EN  defined   -> round-robin arbitration between requesters
//                      undefined -> fixed priority, bit 0 > bit 1 > bit 2
//
// Parameters:
//   CLK_HZ       clock cycles per 1 Hz tick (minimum 2)
//
// Ports:
//   clock        system clock; all logic runs on the rising edge
//   systemReset  synchronous reset, active low
//   req[2:0]     level request, one bit per requester
//   value0..2    countdown length in seconds for each requester
//   grant[2:0]   one-hot owner of the timer; zero when idle
//   expired[2:0] one-cycle one-hot pulse to the owner on completion
//   tick1Hz      one-cycle pulse per elapsed second of a countdown
//   remaining    seconds left for the current owner; zero when idle
//   busy         high while a countdown is running
//
// Every output comes straight from a flop. There is no combinational path
// from req or value* to any output.
// -----------------------------------------------------------------------------
module timer_scheduler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clock,
    input  logic       systemReset,
    input  logic [2:0] req,
    input  logic [3:0] value0,
    input  logic [3:0] value1,
    input  logic [3:0] value2,
    output logic [2:0] grant,
    output logic [2:0] expired,
    output logic       tick1Hz,
    output logic [3:0] remaining,
    output logic       busy
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    expired_q, expired_d;
    logic          tick_q, tick_d;
    logic [3:0]    remaining_q, remaining_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] presc_q, presc_d;

    // -------------------------------------------------------------------------
    // Winner selection (one-hot) from the current requests
    // -------------------------------------------------------------------------
    logic [2:0] win;

`ifdef TIMER_SCHED_RR_EN
    // ptr_q is the first requester looked at in the next search. It is
    // updated only when a grant is actually issued.
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win_idx;

    always_comb begin
        logic [2:0] idx;
        win     = 3'b000;
        win_idx = 2'd0;
        idx     = 3'd0;
        // Walk from the farthest candidate to the nearest one, so the
        // nearest requesting bit is the one that remains in win.
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (req[idx[1:0]]) begin
                win     = 3'b001 << idx[1:0];
                win_idx = idx[1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && req != 3'b000) begin
            ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!systemReset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win = 3'b000;
        if (req[0]) begin
            win = 3'b001;
        end else if (req[1]) begin
            win = 3'b010;
        end else if (req[2]) begin
            win = 3'b100;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Countdown length of the winner (AND-OR mux on the one-hot win vector)
    // -------------------------------------------------------------------------
    logic [3:0] value_arr [3];
    logic [3:0] value_masked [3];
    logic [3:0] win_value;

    assign value_arr[0] = value0;
    assign value_arr[1] = value1;
    assign value_arr[2] = value2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_value_mask
            assign value_masked[gi] = value_arr[gi] & {4{win[gi]}};
        end
    endgenerate

    assign win_value = value_masked[0] | value_masked[1] | value_masked[2];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        expired_d   = 3'b000;
        tick_d      = 1'b0;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        presc_d     = presc_q;

        case (state_q)
            ST_IDLE: begin
                if (req != 3'b000) begin
                    state_d     = ST_RUN;
                    grant_d     = win;
                    remaining_d = win_value;
                    presc_d     = '0;
                    busy_d      = 1'b1;
                end
            end

            ST_RUN: begin
                if ((req & grant_q) == 3'b000) begin
                    // The owner released the timer. An abort takes priority
                    // over an expiry in the same cycle, so no pulse is issued.
                    state_d     = ST_IDLE;
                    grant_d     = 3'b000;
                    remaining_d = 4'd0;
                    presc_d     = '0;
                    busy_d      = 1'b0;
                end else if (remaining_q == 4'd0) begin
                    // A zero-length request expires immediately, without a tick.
                    state_d   = ST_DONE;
                    expired_d = grant_q;
                    grant_d   = 3'b000;
                    presc_d   = '0;
                    busy_d    = 1'b0;
                end else if (presc_q == PRESC_MAX) begin
                    tick_d  = 1'b1;
                    presc_d = '0;
                    if (remaining_q == 4'd1) begin
                        state_d     = ST_DONE;
                        expired_d   = grant_q;
                        grant_d     = 3'b000;
                        remaining_d = 4'd0;
                        busy_d      = 1'b0;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                busy_d  = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                grant_d     = 3'b000;
                remaining_d = 4'd0;
                presc_d     = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!systemReset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 3'b000;
            expired_q   <= 3'b000;
            tick_q      <= 1'b0;
            remaining_q <= 4'd0;
            busy_q      <= 1'b0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            expired_q   <= expired_d;
            tick_q      <= tick_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            presc_q     <= presc_d;
        end
    end

    assign grant     = grant_q;
    assign expired   = expired_q;
    assign tick1Hz   = tick_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
//
// Self-checking bench for timer_scheduler, run with CLK_HZ = 4.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge. Expected grants are queued when a request is driven and
// popped when the DUT issues a grant.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;

    localparam int HZ = 4;

    logic       clock = 1'b0;
    logic       systemReset;
    logic [2:0] req;
    logic [3:0] value0, value1, value2;
    logic [2:0] grant, expired;
    logic       tick1Hz;
    logic [3:0] remaining;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    timer_scheduler #(.CLK_HZ(HZ)) dut (
        .clock      (clock),
        .systemReset(systemReset),
        .req        (req),
        .value0     (value0),
        .value1     (value1),
        .value2     (value2),
        .grant      (grant),
        .expired    (expired),
        .tick1Hz    (tick1Hz),
        .remaining  (remaining),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] req;
        logic [3:0] v0;
        logic [3:0] v1;
        logic [3:0] v2;
        logic [3:0] v0_late;   // value0 driven after the grant edge
        logic [2:0] exp_grant;
        logic [3:0] exp_val;
    } vec_t;

    typedef struct {
        logic [2:0] g;
        logic [3:0] v;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // grant and expired must each be one-hot or zero at all times, and must
    // never both be non-zero in the same cycle.
    always @(negedge clock) begin
        if (systemReset === 1'b1) begin
            check("onehot0_grant", int'($onehot0(grant)), 1);
            check("onehot0_expired", int'($onehot0(expired)), 1);
            check("grant_and_expired", int'((grant != 3'b000) && (expired != 3'b000)), 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        systemReset = 1'b0;
        req = 3'b000;
        repeat (2) @(negedge clock);
        systemReset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int row);
        sb_t e;
        int  ticks;
        int  done;
        int  exp_cyc;
        string t;
        t = $sformatf("row%0d", row);
        @(negedge clock);
        req    = v.req;
        value0 = v.v0;
        value1 = v.v1;
        value2 = v.v2;
        sb_q.push_back('{g: v.exp_grant, v: v.exp_val});
        @(negedge clock);
        e = sb_q.pop_front();
        $display("[TB] %s req=%b grant=%b remaining=%0d", t, v.req, grant, remaining);
        check({t, "_grant"}, int'(grant), int'(e.g));
        check({t, "_remaining0"}, int'(remaining), int'(e.v));
        check({t, "_busy"}, int'(busy), 1);
        value0  = v.v0_late;
        ticks   = 0;
        done    = 0;
        exp_cyc = (e.v == 4'd0) ? 1 : int'(e.v) * HZ;
        for (int k = 1; k <= 80 && done == 0; k++) begin
            @(negedge clock);
            if (tick1Hz) begin
                ticks++;
                check({t, "_remaining_at_tick"}, int'(remaining), int'(e.v) - ticks);
            end
            if (expired != 3'b000) begin
                done = 1;
                check({t, "_expired"}, int'(expired), int'(e.g));
                check({t, "_expiry_cycle"}, k, exp_cyc);
                check({t, "_tick_count"}, ticks, int'(e.v));
                check({t, "_grant_at_expiry"}, int'(grant), 0);
                check({t, "_busy_at_expiry"}, int'(busy), 0);
            end
        end
        if (done == 0) begin
            check({t, "_expiry_timeout"}, 1, 0);
        end
        req = 3'b000;
    endtask

    initial begin
        sb_t        e;
        int         cnt;
        logic [2:0] seen;
        logic [2:0] rr_exp [4];

        systemReset = 1'b0;
        req    = 3'b000;
        value0 = 4'd0;
        value1 = 4'd0;
        value2 = 4'd0;

        //            req     v0     v1     v2     v0_late exp_grant exp_val
        vecs[0] = '{3'b001, 4'd3,  4'd0,  4'd0,  4'd3,  3'b001, 4'd3};
        vecs[1] = '{3'b111, 4'd2,  4'd5,  4'd7,  4'd2,  3'b001, 4'd2};
        vecs[2] = '{3'b110, 4'd9,  4'd2,  4'd4,  4'd9,  3'b010, 4'd2};
        vecs[3] = '{3'b100, 4'd6,  4'd6,  4'd1,  4'd6,  3'b100, 4'd1};
        vecs[4] = '{3'b100, 4'd3,  4'd3,  4'd0,  4'd3,  3'b100, 4'd0};
        vecs[5] = '{3'b010, 4'd1,  4'd15, 4'd1,  4'd1,  3'b010, 4'd15};
        vecs[6] = '{3'b001, 4'd5,  4'd0,  4'd0,  4'd1,  3'b001, 4'd5};

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_grant", int'(grant), 0);
        check("reset_expired", int'(expired), 0);
        check("reset_tick", int'(tick1Hz), 0);
        check("reset_remaining", int'(remaining), 0);
        check("reset_busy", int'(busy), 0);
        $display("[TB] reset grant=%b busy=%b remaining=%0d", grant, busy, remaining);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_vec(vecs[i], i);
        end

        // Owner drops its request mid-countdown
        do_reset();
        @(negedge clock);
        req = 3'b010;
        value1 = 4'd3;
        @(negedge clock);
        check("abort_grant", int'(grant), 2);
        repeat (4) @(negedge clock);
        check("abort_tick", int'(tick1Hz), 1);
        check("abort_remaining2", int'(remaining), 2);
        req = 3'b000;
        @(negedge clock);
        check("abort_grant_clear", int'(grant), 0);
        check("abort_remaining_clear", int'(remaining), 0);
        check("abort_busy", int'(busy), 0);
        seen = expired;
        repeat (6) begin
            @(negedge clock);
            seen = seen | expired;
        end
        check("abort_no_expired", int'(seen), 0);
        $display("[TB] abort grant=%b remaining=%0d expired_seen=%b", grant, remaining, seen);

        // Abort and expiry in the same cycle: the abort wins
        do_reset();
        @(negedge clock);
        req = 3'b001;
        value0 = 4'd1;
        @(negedge clock);
        repeat (3) @(negedge clock);
        req = 3'b000;
        @(negedge clock);
        check("abort_vs_expiry_expired", int'(expired), 0);
        check("abort_vs_expiry_grant", int'(grant), 0);
        check("abort_vs_expiry_remaining", int'(remaining), 0);
        $display("[TB] abort_vs_expiry expired=%b grant=%b", expired, grant);

        // Reset at the final tick edge suppresses the expiry
        do_reset();
        @(negedge clock);
        req = 3'b001;
        value0 = 4'd1;
        @(negedge clock);
        check("rst_run_grant", int'(grant), 1);
        repeat (3) @(negedge clock);
        systemReset = 1'b0;
        @(negedge clock);
        check("rst_run_grant0", int'(grant), 0);
        check("rst_run_expired", int'(expired), 0);
        check("rst_run_tick", int'(tick1Hz), 0);
        check("rst_run_remaining", int'(remaining), 0);
        check("rst_run_busy", int'(busy), 0);
        $display("[TB] reset_mid_run grant=%b expired=%b busy=%b", grant, expired, busy);
        req = 3'b000;
        systemReset = 1'b1;

        // A request held through expiry is granted again two cycles later
        do_reset();
        @(negedge clock);
        req = 3'b001;
        value0 = 4'd1;
        @(negedge clock);
        repeat (4) @(negedge clock);
        check("regrant_expired", int'(expired), 1);
        @(negedge clock);
        check("regrant_gap_grant", int'(grant), 0);
        @(negedge clock);
        check("regrant_grant", int'(grant), 1);
        $display("[TB] regrant grant=%b remaining=%0d", grant, remaining);
        req = 3'b000;

        // Arbitration order with all three requesters held high
`ifdef TIMER_SCHED_RR_EN
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
`else
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001; rr_exp[3] = 3'b001;
`endif
        do_reset();
        @(negedge clock);
        value0 = 4'd1;
        value1 = 4'd1;
        value2 = 4'd1;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{g: rr_exp[i], v: 4'd1});
        end
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            while (grant == 3'b000 && cnt < 10) begin
                @(negedge clock);
                cnt++;
            end
            if (cnt >= 10) check("arb_grant_timeout", 1, 0);
            e = sb_q.pop_front();
            check($sformatf("arb_grant%0d", i), int'(grant), int'(e.g));
            $display("[TB] arb%0d grant=%b", i, grant);
            cnt = 0;
            while (expired == 3'b000 && cnt < 10) begin
                @(negedge clock);
                cnt++;
            end
            if (cnt >= 10) check("arb_expired_timeout", 1, 0);
            check($sformatf("arb_expired%0d", i), int'(expired), int'(e.g));
        end
        req = 3'b000;
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
